shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_pkg.sv | 15 +
 rtl/shifter1posicion.sv | 17 +
 rtl/shift_sequencer.sv | 76 +++++++
 tb/tb_shift_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared FSM state and shift-mode encodings for shift_sequencer
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

endpackage

// File: rtl/shifter1posicion.sv
// rtl/shifter1posicion.sv - combinational one-position shifter with selectable direction and fill bit
module shifter1posicion #(
  parameter int N = 8
) (
  input  logic [N-1:0] data_in,
  input  logic         dir,
  input  logic         fill,
  output logic [N-1:0] data_out
);

  // dir=0 moves toward the MSB, dir=1 toward the LSB; fill enters the vacated end
  always_comb begin
    if (dir) data_out = {fill, data_in[N-1:1]};
    else     data_out = {data_in[N-2:0], fill};
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle LSL/LSR/ASR sequencer shifting one bit position per clock
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  data_in,
  input  logic [AW-1:0] amount,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  data_out
);

  localparam logic [AW-1:0] N_AMT = AW'(N);

  state_t        state;
  logic [N-1:0]  work;
  logic [1:0]    mode_q;
  logic [AW-1:0] count;
  logic [AW-1:0] amount_clamped;
  logic          shift_dir;
  logic          shift_fill;
  logic [N-1:0]  shifted;

  assign amount_clamped = (amount > N_AMT) ? N_AMT : amount;

  // LSL shifts left with zero fill; LSR/ASR shift right, ASR re-inserting the sign bit
  always_comb begin
    shift_dir  = (mode_q != MODE_LSL);
    shift_fill = (mode_q == MODE_ASR) ? work[N-1] : 1'b0;
  end

  shifter1posicion #(.N(N)) u_shift (
    .data_in  (work),
    .dir      (shift_dir),
    .fill     (shift_fill),
    .data_out (shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      mode_q <= MODE_LSL;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work   <= data_in;
            mode_q <= mode;
            count  <= amount_clamped;
            state  <= ((amount_clamped != '0) && (mode != MODE_RSV)) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          work  <= shifted;
          count <= count - AW'(1);
          if (count == AW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign data_out = work;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer with N=8
module tb_shift_sequencer;

  localparam int N  = 8;
  localparam int AW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  data_in = '0;
  logic [AW-1:0] amount = '0;
  logic [1:0]    mode = 2'b00;
  logic          busy;
  logic          done;
  logic [N-1:0]  data_out;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  shift_sequencer #(.N(N), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .amount   (amount),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Reference model: an accepted operation is visible for L = k+1 cycles (k = clamped
  // amount, or 0 for mode 11); in its c-th cycle the output holds the operand shifted
  // by min(c-1, k) positions, and the final value is held once idle.
  bit          m_active = 1'b0;
  int          m_cyc = 0;
  int          m_len = 0;
  int          m_k = 0;
  logic [N-1:0] m_data = '0;
  logic [1:0]  m_mode = 2'b00;
  logic [N-1:0] m_hold = '0;

  function automatic logic [N-1:0] shift_by(input logic [N-1:0] d, input logic [1:0] md, input int s);
    logic [N-1:0] r;
    case (md)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = $unsigned($signed(d) >>> s);
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_hold   = '0;
    end else if (m_active) begin
      if (m_cyc == m_len) begin
        m_active = 1'b0;
        m_hold   = shift_by(m_data, m_mode, m_k);
      end else begin
        m_cyc++;
      end
    end else if (start) begin
      m_data   = data_in;
      m_mode   = mode;
      m_k      = (mode == 2'b11) ? 0 : ((int'(amount) > N) ? N : int'(amount));
      m_len    = m_k + 1;
      m_cyc    = 1;
      m_active = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic         e_busy;
      logic         e_done;
      logic [N-1:0] e_data;
      int           s;
      e_busy = m_active;
      e_done = m_active && (m_cyc == m_len);
      s      = (m_cyc - 1 < m_k) ? m_cyc - 1 : m_k;
      e_data = m_active ? shift_by(m_data, m_mode, s) : m_hold;
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL model_busy t=%0t got %b want %b", $time, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        errors++;
        $display("FAIL model_done t=%0t got %b want %b", $time, done, e_done);
      end
      checks++;
      if (data_out !== e_data) begin
        errors++;
        $display("FAIL model_data t=%0t got %h want %h", $time, data_out, e_data);
      end
    end
  end

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_val("wait_idle_timeout", 1, 0);
  endtask

  // Launch one operation; optionally re-pulse start with other data at cycle 2
  task automatic run_op(input string name, input logic [7:0] d, input int amt, input logic [1:0] md,
                        input logic [7:0] exp_data, input int exp_lat, input bit poke);
    int cyc;
    wait_idle();
    #1;
    start   = 1'b1;
    data_in = d;
    amount  = AW'(amt);
    mode    = md;
    @(negedge clk);
    cyc = 1;
    #1;
    start   = 1'b0;
    data_in = 8'h3C;
    amount  = AW'(1);
    mode    = 2'b00;
    #1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 2) begin
        #1;
        start   = 1'b1;
        data_in = 8'hFF;
        amount  = AW'(2);
        mode    = 2'b01;
        @(negedge clk);
        cyc++;
        #1;
        start = 1'b0;
      end
    end
    check_val({name, "_latency"}, cyc, exp_lat);
    check_val({name, "_data"}, int'(data_out), int'(exp_data));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_data", int'(data_out), 0);
    #1 rst = 1'b0;

    run_op("lsl_81_1",     8'h81, 1,  2'b00, 8'h02, 2, 1'b0);
    run_op("lsr_90_3",     8'h90, 3,  2'b01, 8'h12, 4, 1'b0);
    run_op("asr_90_3",     8'h90, 3,  2'b10, 8'hF2, 4, 1'b0);
    run_op("lsl_a5_0",     8'hA5, 0,  2'b00, 8'hA5, 1, 1'b0);
    run_op("lsr_a5_0",     8'hA5, 0,  2'b01, 8'hA5, 1, 1'b0);
    run_op("asr_a5_0",     8'hA5, 0,  2'b10, 8'hA5, 1, 1'b0);
    run_op("rsv_a5_5",     8'hA5, 5,  2'b11, 8'hA5, 1, 1'b0);
    run_op("lsr_ff_12",    8'hFF, 12, 2'b01, 8'h00, 9, 1'b0);
    run_op("asr_80_12",    8'h80, 12, 2'b10, 8'hFF, 9, 1'b0);
    run_op("lsl_01_8",     8'h01, 8,  2'b00, 8'h00, 9, 1'b0);
    run_op("asr_7f_7",     8'h7F, 7,  2'b10, 8'h00, 8, 1'b0);
    run_op("lsl_81_3_poke", 8'h81, 3, 2'b00, 8'h08, 4, 1'b1);

    // Reset during the second SHIFT cycle of a long ASR
    wait_idle();
    #1;
    start = 1'b1; data_in = 8'h90; amount = AW'(5); mode = 2'b10;
    @(negedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_done", int'(done), 0);
    check_val("abort_data", int'(data_out), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("abort_no_done", int'(done), 0);
    end
    run_op("post_rst_lsl", 8'h01, 2, 2'b00, 8'h04, 3, 1'b0);
    repeat (3) @(negedge clk);
    check_val("final_hold", int'(data_out), 8'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
